sba_csr: RTL and testbench
==========================

Name: sba_csr

Overview:
- Debug-module register front end for System Bus Access. Decodes DMI requests to sbcs, sbaddress0/1 and sbdata0/1.
- Holds the architectural SBA state and drives the SBA master's control, address and data inputs.
- Captures the master's read data, incremented address and error status.
- Sits directly upstream of the SBA master, between the DMI request/response channel and the master.

Parameters:
- SB_ASIZE, 64, value reported in sbcs.sbasize (7 bits); address register is 64 bits regardless.
- SB_ACCESS_MASK, 5'b01111, reported in sbcs.sbaccess128..sbaccess8 (bits 4:0).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- dmactive_i  in  1  synchronous clear when low
- dmi_req_valid_i  in  1  DMI request valid
- dmi_req_ready_o  out  1  DMI request ready
- dmi_req_addr_i  in  7  DMI register address
- dmi_req_op_i  in  2  1=read, 2=write, others ignored
- dmi_req_data_i  in  32  write data
- dmi_resp_valid_o  out  1  response valid
- dmi_resp_ready_i  in  1  response accepted
- dmi_resp_data_o  out  32  read data
- dmi_resp_resp_o  out  2  always 0
- sbaddress_o  out  64  address register to master
- sbaddress_write_valid_o  out  1  1-cycle pulse on legal sbaddress0 write
- sbreadonaddr_o, sbautoincrement_o, sbreadondata_o  out  1 each  sbcs control bits
- sbaccess_o  out  3  sbcs.sbaccess
- sbdata_o  out  64  write data register to master
- sbdata_write_valid_o  out  1  1-cycle pulse on legal sbdata0 write
- sbdata_read_valid_o  out  1  1-cycle pulse on legal sbdata0 read
- sbaddress_i  in  64  next address from master
- sbdata_i  in  64  read data from master
- sbdata_valid_i  in  1  master transaction complete
- sbbusy_i  in  1  master busy
- sberror_valid_i  in  1  master error strobe
- sberror_i  in  3  master error code

Behaviour:
- Register map (dmi_req_addr_i): 0x38 sbcs, 0x39 sbaddress0, 0x3a sbaddress1, 0x3c sbdata0, 0x3d sbdata1.
  - Other addresses: read 0, write ignored, normal response.
- sbcs fields:
  - [31:29] sbversion=1
  - [22] sbbusyerror, W1C
  - [21] sbbusy = sbbusy_i, read-only
  - [20] sbreadonaddr, R/W
  - [19:17] sbaccess, R/W
  - [16] sbautoincrement, R/W
  - [15] sbreadondata, R/W
  - [14:12] sberror, W1C
  - [11:5] SB_ASIZE
  - [4:0] SB_ACCESS_MASK
- DMI FSM, states IDLE and RESP:
  - IDLE: dmi_req_ready_o=1. Request accepted when valid&ready; go to RESP.
  - RESP: dmi_resp_valid_o=1, dmi_req_ready_o=0; response data is registered at acceptance. Go to IDLE when dmi_resp_ready_i.
  - One request outstanding at a time; response is valid exactly one cycle after acceptance.
- Register writes and reads:
  - sbaddress1 and sbdata1 writes update bits [63:32] with no trigger.
  - sbaddress0 and sbdata0 writes update bits [31:0] and may trigger an access (next bullet).
  - A sbdata0 read returns the current data[31:0] and may trigger an access.
- Trigger rule:
  - A legal trigger requires sbbusy_i=0, sberror=0 and sbbusyerror=0.
  - If sbbusy_i=1 at acceptance: set sbbusyerror, discard the write (register unchanged), no pulse; a read still returns the stale value.
  - If sberror!=0 or sbbusyerror=1: the access is ignored silently (no update, no pulse, no flag change).
- Pulses are registered:
  - Asserted in the cycle after acceptance, coincident with dmi_resp_valid_o, for exactly 1 cycle.
  - The new register value is visible on sbaddress_o/sbdata_o in the same cycle.
- pending_read flag:
  - Set with the sbaddress_write_valid_o pulse when sbreadonaddr=1.
  - Set with the sbdata_read_valid_o pulse when sbreadondata=1.
- Completion on sbdata_valid_i: address register <= sbaddress_i (this carries the auto-increment); if pending_read, data register <= sbdata_i; then clear pending_read.
- Error on sberror_valid_i: if sberror==0, sberror <= sberror_i; clear pending_read.
- Simultaneous events:
  - A hardware set of sberror/sbbusyerror wins over a W1C in the same cycle.
  - A master capture wins over a DMI write to the same register.
- Reset (rst_ni low) and dmactive_i low set the same values:
  - All registers 0 except sbaccess=3'd2.
  - FSM to IDLE; all pulses 0; pending_read 0.
  - Outputs: dmi_req_ready_o=1, dmi_resp_valid_o=0, dmi_resp_data_o=0.
  - Reset mid-transaction drops any pending response.

Test Plan:
- Reset, then read 0x38 -> resp data 0x2004_080F (sbversion=1, sbaccess=2, sbasize=64, mask=0xF); sbaccess_o=2, all pulses 0.
- Write 0x3a=0x0000_0001, then write sbcs with sbreadonaddr=1, sbaccess=3, then write 0x39=0x8000_0000 -> sbaddress_o=0x0000_0001_8000_0000; single sbaddress_write_valid_o pulse together with resp_valid. Master returns sbdata_i=0xDEAD_BEEF_CAFE_F00D -> read 0x3c gives 0xCAFE_F00D, read 0x3d gives 0xDEAD_BEEF.
- sbautoincrement=1, sbaccess=2, write 0x3c=0x1234_5678 -> sbdata_write_valid_o pulse; sbdata_valid_i with sbaddress_i=0x1004 -> sbaddress_o=0x1004; data register unchanged.
- Write 0x39 while sbbusy_i=1 -> no pulse, address unchanged, sbcs[22]=1. Next sbdata0 read -> no pulse. Write sbcs with bit 22=1 -> cleared.
- sberror_valid_i with sberror_i=3 -> sbcs[14:12]=3, next write to 0x39 is ignored. W1C 3'b111 in the same cycle as a new sberror_valid_i -> sberror remains set.
- dmi_resp_ready_i held low 5 cycles -> resp_valid and data stable, req_ready=0. Drop dmactive_i mid-RESP -> IDLE and all registers reset the next cycle.

Source files
------------

// File: rtl/sba_csr.sv
// System Bus Access register front end for the debug module: decodes DMI requests to
// sbcs/sbaddress/sbdata, drives the SBA master and captures its results.
module sba_csr #(
  parameter int unsigned SB_ASIZE       = 64,
  parameter logic [4:0]  SB_ACCESS_MASK = 5'b01111
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmactive_i,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  input  logic [6:0]  dmi_req_addr_i,
  input  logic [1:0]  dmi_req_op_i,
  input  logic [31:0] dmi_req_data_i,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic [31:0] dmi_resp_data_o,
  output logic [1:0]  dmi_resp_resp_o,
  output logic [63:0] sbaddress_o,
  output logic        sbaddress_write_valid_o,
  output logic        sbreadonaddr_o,
  output logic        sbautoincrement_o,
  output logic        sbreadondata_o,
  output logic [2:0]  sbaccess_o,
  output logic [63:0] sbdata_o,
  output logic        sbdata_write_valid_o,
  output logic        sbdata_read_valid_o,
  input  logic [63:0] sbaddress_i,
  input  logic [63:0] sbdata_i,
  input  logic        sbdata_valid_i,
  input  logic        sbbusy_i,
  input  logic        sberror_valid_i,
  input  logic [2:0]  sberror_i
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StResp = 1'b1;

  localparam logic [6:0] AddrSbcs  = 7'h38;
  localparam logic [6:0] AddrAddr0 = 7'h39;
  localparam logic [6:0] AddrAddr1 = 7'h3a;
  localparam logic [6:0] AddrData0 = 7'h3c;
  localparam logic [6:0] AddrData1 = 7'h3d;

  localparam logic [6:0] SbAsize = 7'(SB_ASIZE);

  logic [0:0]  r_state;
  logic [31:0] r_resp_data;
  logic [63:0] r_sbaddress;
  logic [63:0] r_sbdata;
  logic        r_sbbusyerror;
  logic        r_sbreadonaddr;
  logic [2:0]  r_sbaccess;
  logic        r_sbautoincrement;
  logic        r_sbreadondata;
  logic [2:0]  r_sberror;
  logic        r_pending_read;
  logic        r_addr_wr_pulse;
  logic        r_data_wr_pulse;
  logic        r_data_rd_pulse;

  logic        w_accept;
  logic        w_rd;
  logic        w_wr;
  logic        w_wr_sbcs;
  logic        w_trig_req;
  logic        w_trig_busy;
  logic        w_trig_ok;
  logic        w_addr0_go;
  logic        w_data0_wr_go;
  logic        w_data0_rd_go;
  logic        w_pend_set;
  logic [31:0] w_sbcs;
  logic [31:0] w_rdata;

  assign w_accept  = dmi_req_valid_i & (r_state == StIdle);
  assign w_rd      = w_accept & (dmi_req_op_i == 2'd1);
  assign w_wr      = w_accept & (dmi_req_op_i == 2'd2);
  assign w_wr_sbcs = w_wr & (dmi_req_addr_i == AddrSbcs);

  // Only sbaddress0 writes and sbdata0 reads/writes may start a bus access.
  assign w_trig_req  = (w_wr & ((dmi_req_addr_i == AddrAddr0) | (dmi_req_addr_i == AddrData0)))
                     | (w_rd & (dmi_req_addr_i == AddrData0));
  assign w_trig_busy = w_trig_req & sbbusy_i;
  assign w_trig_ok   = w_trig_req & ~sbbusy_i & (r_sberror == 3'd0) & ~r_sbbusyerror;

  assign w_addr0_go    = w_trig_ok & w_wr & (dmi_req_addr_i == AddrAddr0);
  assign w_data0_wr_go = w_trig_ok & w_wr & (dmi_req_addr_i == AddrData0);
  assign w_data0_rd_go = w_trig_ok & w_rd;
  assign w_pend_set    = (w_addr0_go & r_sbreadonaddr) | (w_data0_rd_go & r_sbreadondata);

  assign w_sbcs = {3'd1, 6'd0, r_sbbusyerror, sbbusy_i, r_sbreadonaddr, r_sbaccess,
                   r_sbautoincrement, r_sbreadondata, r_sberror, SbAsize, SB_ACCESS_MASK};

  always_comb begin
    w_rdata = 32'd0;
    if (w_rd) begin
      case (dmi_req_addr_i)
        AddrSbcs:  w_rdata = w_sbcs;
        AddrAddr0: w_rdata = r_sbaddress[31:0];
        AddrAddr1: w_rdata = r_sbaddress[63:32];
        AddrData0: w_rdata = r_sbdata[31:0];
        AddrData1: w_rdata = r_sbdata[63:32];
        default:   w_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state           <= StIdle;
      r_resp_data       <= 32'd0;
      r_sbaddress       <= 64'd0;
      r_sbdata          <= 64'd0;
      r_sbbusyerror     <= 1'b0;
      r_sbreadonaddr    <= 1'b0;
      r_sbaccess        <= 3'd2;
      r_sbautoincrement <= 1'b0;
      r_sbreadondata    <= 1'b0;
      r_sberror         <= 3'd0;
      r_pending_read    <= 1'b0;
      r_addr_wr_pulse   <= 1'b0;
      r_data_wr_pulse   <= 1'b0;
      r_data_rd_pulse   <= 1'b0;
    end else if (!dmactive_i) begin
      r_state           <= StIdle;
      r_resp_data       <= 32'd0;
      r_sbaddress       <= 64'd0;
      r_sbdata          <= 64'd0;
      r_sbbusyerror     <= 1'b0;
      r_sbreadonaddr    <= 1'b0;
      r_sbaccess        <= 3'd2;
      r_sbautoincrement <= 1'b0;
      r_sbreadondata    <= 1'b0;
      r_sberror         <= 3'd0;
      r_pending_read    <= 1'b0;
      r_addr_wr_pulse   <= 1'b0;
      r_data_wr_pulse   <= 1'b0;
      r_data_rd_pulse   <= 1'b0;
    end else begin
      if (r_state == StIdle) begin
        if (w_accept) begin
          r_state     <= StResp;
          r_resp_data <= w_rdata;
        end
      end else if (dmi_resp_ready_i) begin
        r_state <= StIdle;
      end

      r_addr_wr_pulse <= w_addr0_go;
      r_data_wr_pulse <= w_data0_wr_go;
      r_data_rd_pulse <= w_data0_rd_go;

      if (w_wr_sbcs) begin
        r_sbreadonaddr    <= dmi_req_data_i[20];
        r_sbaccess        <= dmi_req_data_i[19:17];
        r_sbautoincrement <= dmi_req_data_i[16];
        r_sbreadondata    <= dmi_req_data_i[15];
      end

      if (w_trig_busy) begin
        r_sbbusyerror <= 1'b1;
      end else if (w_wr_sbcs && dmi_req_data_i[22]) begin
        r_sbbusyerror <= 1'b0;
      end

      // A master error strobe suppresses a same-cycle W1C so the error is never lost.
      if (sberror_valid_i) begin
        if (r_sberror == 3'd0) r_sberror <= sberror_i;
      end else if (w_wr_sbcs) begin
        r_sberror <= r_sberror & ~dmi_req_data_i[14:12];
      end

      if (sbdata_valid_i) begin
        r_sbaddress <= sbaddress_i;
      end else begin
        if (w_wr && dmi_req_addr_i == AddrAddr1) r_sbaddress[63:32] <= dmi_req_data_i;
        if (w_addr0_go) r_sbaddress[31:0] <= dmi_req_data_i;
      end

      if (sbdata_valid_i && r_pending_read) begin
        r_sbdata <= sbdata_i;
      end else begin
        if (w_wr && dmi_req_addr_i == AddrData1) r_sbdata[63:32] <= dmi_req_data_i;
        if (w_data0_wr_go) r_sbdata[31:0] <= dmi_req_data_i;
      end

      if (w_pend_set) begin
        r_pending_read <= 1'b1;
      end else if (sbdata_valid_i || sberror_valid_i) begin
        r_pending_read <= 1'b0;
      end
    end
  end

  assign dmi_req_ready_o         = (r_state == StIdle);
  assign dmi_resp_valid_o        = (r_state == StResp);
  assign dmi_resp_data_o         = r_resp_data;
  assign dmi_resp_resp_o         = 2'd0;
  assign sbaddress_o             = r_sbaddress;
  assign sbdata_o                = r_sbdata;
  assign sbaddress_write_valid_o = r_addr_wr_pulse;
  assign sbdata_write_valid_o    = r_data_wr_pulse;
  assign sbdata_read_valid_o     = r_data_rd_pulse;
  assign sbreadonaddr_o          = r_sbreadonaddr;
  assign sbautoincrement_o       = r_sbautoincrement;
  assign sbreadondata_o          = r_sbreadondata;
  assign sbaccess_o              = r_sbaccess;

endmodule

// File: tb/tb_sba_csr.sv
// Self-checking bench for sba_csr: directed scenarios plus randomized DMI/master traffic
// checked against a register-level behavioural model.
module tb_sba_csr;

  localparam logic [6:0] ASbcs  = 7'h38;
  localparam logic [6:0] AAddr0 = 7'h39;
  localparam logic [6:0] AAddr1 = 7'h3a;
  localparam logic [6:0] AData0 = 7'h3c;
  localparam logic [6:0] AData1 = 7'h3d;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dmactive_i;
  logic        dmi_req_valid_i;
  logic        dmi_req_ready_o;
  logic [6:0]  dmi_req_addr_i;
  logic [1:0]  dmi_req_op_i;
  logic [31:0] dmi_req_data_i;
  logic        dmi_resp_valid_o;
  logic        dmi_resp_ready_i;
  logic [31:0] dmi_resp_data_o;
  logic [1:0]  dmi_resp_resp_o;
  logic [63:0] sbaddress_o;
  logic        sbaddress_write_valid_o;
  logic        sbreadonaddr_o;
  logic        sbautoincrement_o;
  logic        sbreadondata_o;
  logic [2:0]  sbaccess_o;
  logic [63:0] sbdata_o;
  logic        sbdata_write_valid_o;
  logic        sbdata_read_valid_o;
  logic [63:0] sbaddress_i;
  logic [63:0] sbdata_i;
  logic        sbdata_valid_i;
  logic        sbbusy_i;
  logic        sberror_valid_i;
  logic [2:0]  sberror_i;

  always #5 clk_i = ~clk_i;

  sba_csr dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .dmactive_i              (dmactive_i),
    .dmi_req_valid_i         (dmi_req_valid_i),
    .dmi_req_ready_o         (dmi_req_ready_o),
    .dmi_req_addr_i          (dmi_req_addr_i),
    .dmi_req_op_i            (dmi_req_op_i),
    .dmi_req_data_i          (dmi_req_data_i),
    .dmi_resp_valid_o        (dmi_resp_valid_o),
    .dmi_resp_ready_i        (dmi_resp_ready_i),
    .dmi_resp_data_o         (dmi_resp_data_o),
    .dmi_resp_resp_o         (dmi_resp_resp_o),
    .sbaddress_o             (sbaddress_o),
    .sbaddress_write_valid_o (sbaddress_write_valid_o),
    .sbreadonaddr_o          (sbreadonaddr_o),
    .sbautoincrement_o       (sbautoincrement_o),
    .sbreadondata_o          (sbreadondata_o),
    .sbaccess_o              (sbaccess_o),
    .sbdata_o                (sbdata_o),
    .sbdata_write_valid_o    (sbdata_write_valid_o),
    .sbdata_read_valid_o     (sbdata_read_valid_o),
    .sbaddress_i             (sbaddress_i),
    .sbdata_i                (sbdata_i),
    .sbdata_valid_i          (sbdata_valid_i),
    .sbbusy_i                (sbbusy_i),
    .sberror_valid_i         (sberror_valid_i),
    .sberror_i               (sberror_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural model state
  logic [63:0] m_addr, m_data;
  logic        m_busyerr, m_roa, m_ainc, m_rod, m_pend;
  logic [2:0]  m_err, m_acc;
  logic        g_err_with_req = 1'b0;
  logic [2:0]  g_err_code = 3'd0;

  task automatic model_reset();
    m_addr = '0; m_data = '0; m_busyerr = 0; m_roa = 0; m_ainc = 0; m_rod = 0;
    m_pend = 0; m_err = 0; m_acc = 3'd2;
  endtask

  function automatic logic [31:0] m_sbcs(input logic busy);
    int unsigned v;
    v = (1 << 29) + (int'(m_busyerr) << 22) + (int'(busy) << 21) + (int'(m_roa) << 20)
      + (int'(m_acc) << 17) + (int'(m_ainc) << 16) + (int'(m_rod) << 15)
      + (int'(m_err) << 12) + (64 << 5) + 15;
    return v;
  endfunction

  task automatic check_outputs(input string ctx);
    check_eq({ctx, ":sbaddress"}, sbaddress_o, m_addr);
    check_eq({ctx, ":sbdata"}, sbdata_o, m_data);
    check_eq({ctx, ":sbaccess"}, 64'(sbaccess_o), 64'(m_acc));
    check_eq({ctx, ":ctrl"}, 64'({sbreadonaddr_o, sbautoincrement_o, sbreadondata_o}),
             64'({m_roa, m_ainc, m_rod}));
  endtask

  task automatic check_no_pulse(input string ctx);
    check_eq({ctx, ":pulses"},
             64'({sbaddress_write_valid_o, sbdata_write_valid_o, sbdata_read_valid_o}), 64'd0);
  endtask

  // One full DMI transaction; entered and left at #1 after a rising edge.
  task automatic dmi(input logic [6:0] a, input logic [1:0] op, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd);
    logic [31:0] exp;
    logic trig, ok, epa, epw, epr;
    check_eq("req_ready_idle", 64'(dmi_req_ready_o), 64'd1);
    exp  = 32'd0;
    trig = (op == 2'd2 && (a == AAddr0 || a == AData0)) || (op == 2'd1 && a == AData0);
    ok   = trig && !sbbusy_i && m_err == 3'd0 && !m_busyerr;
    epa  = ok && a == AAddr0;
    epw  = ok && op == 2'd2 && a == AData0;
    epr  = ok && op == 2'd1 && a == AData0;
    if (op == 2'd1) begin
      case (a)
        ASbcs:   exp = m_sbcs(sbbusy_i);
        AAddr0:  exp = m_addr[31:0];
        AAddr1:  exp = m_addr[63:32];
        AData0:  exp = m_data[31:0];
        AData1:  exp = m_data[63:32];
        default: exp = 32'd0;
      endcase
    end else if (op == 2'd2) begin
      case (a)
        ASbcs: begin
          if (wd[22]) m_busyerr = 1'b0;
          if (!g_err_with_req) m_err = m_err & ~wd[14:12];
          m_roa = wd[20]; m_acc = wd[19:17]; m_ainc = wd[16]; m_rod = wd[15];
        end
        AAddr0: if (epa) m_addr[31:0] = wd;
        AAddr1: m_addr[63:32] = wd;
        AData0: if (epw) m_data[31:0] = wd;
        AData1: m_data[63:32] = wd;
        default: ;
      endcase
    end
    if (trig && sbbusy_i) m_busyerr = 1'b1;
    if (g_err_with_req) begin
      if (m_err == 3'd0) m_err = g_err_code;
      m_pend = 1'b0;
    end
    if ((epa && m_roa) || (epr && m_rod)) m_pend = 1'b1;

    dmi_req_valid_i = 1'b1; dmi_req_addr_i = a; dmi_req_op_i = op; dmi_req_data_i = wd;
    if (g_err_with_req) begin sberror_valid_i = 1'b1; sberror_i = g_err_code; end
    @(posedge clk_i); #1;
    dmi_req_valid_i = 1'b0; sberror_valid_i = 1'b0;
    check_eq("resp_valid", 64'(dmi_resp_valid_o), 64'd1);
    check_eq("req_ready_busy", 64'(dmi_req_ready_o), 64'd0);
    check_eq("resp_resp", 64'(dmi_resp_resp_o), 64'd0);
    check_eq("resp_data", 64'(dmi_resp_data_o), 64'(exp));
    check_eq("pulses", 64'({sbaddress_write_valid_o, sbdata_write_valid_o, sbdata_read_valid_o}),
             64'({epa, epw, epr}));
    check_outputs("post_accept");
    rd = dmi_resp_data_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      check_eq("hold_valid", 64'(dmi_resp_valid_o), 64'd1);
      check_eq("hold_ready", 64'(dmi_req_ready_o), 64'd0);
      check_eq("hold_data", 64'(dmi_resp_data_o), 64'(exp));
      check_no_pulse("hold");
    end
    dmi_resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    dmi_resp_ready_i = 1'b0;
    check_eq("resp_done", 64'(dmi_resp_valid_o), 64'd0);
    check_no_pulse("resp_done");
  endtask

  task automatic master_complete(input logic [63:0] a, input logic [63:0] d);
    sbdata_valid_i = 1'b1; sbaddress_i = a; sbdata_i = d;
    @(posedge clk_i); #1;
    sbdata_valid_i = 1'b0;
    m_addr = a;
    if (m_pend) m_data = d;
    m_pend = 1'b0;
    check_outputs("complete");
  endtask

  task automatic master_error(input logic [2:0] c);
    sberror_valid_i = 1'b1; sberror_i = c;
    @(posedge clk_i); #1;
    sberror_valid_i = 1'b0;
    if (m_err == 3'd0) m_err = c;
    m_pend = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [6:0]  addrs [7];
    addrs = '{ASbcs, AAddr0, AAddr1, AData0, AData1, 7'h3b, 7'h10};
    rst_ni = 1'b0; dmactive_i = 1'b1; dmi_req_valid_i = 0; dmi_req_addr_i = '0;
    dmi_req_op_i = '0; dmi_req_data_i = '0; dmi_resp_ready_i = 0; sbaddress_i = '0;
    sbdata_i = '0; sbdata_valid_i = 0; sbbusy_i = 0; sberror_valid_i = 0; sberror_i = '0;
    model_reset();
    #12;
    check_eq("rst_ready", 64'(dmi_req_ready_o), 64'd1);
    check_eq("rst_resp_valid", 64'(dmi_resp_valid_o), 64'd0);
    check_eq("rst_resp_data", 64'(dmi_resp_data_o), 64'd0);
    check_no_pulse("rst");
    check_outputs("rst");
    @(posedge clk_i); #1; rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Reset value of sbcs
    dmi(ASbcs, 2'd1, 32'd0, 0, rd);
    check_eq("sbcs_reset_const", 64'(rd), 64'h2004_080F);

    // Read-on-address with high word
    dmi(AAddr1, 2'd2, 32'h0000_0001, 0, rd);
    dmi(ASbcs, 2'd2, 32'h0016_0000, 0, rd);
    dmi(AAddr0, 2'd2, 32'h8000_0000, 0, rd);
    check_eq("addr_concat", sbaddress_o, 64'h0000_0001_8000_0000);
    master_complete(64'h0000_0001_8000_0000, 64'hDEAD_BEEF_CAFE_F00D);
    dmi(AData0, 2'd1, 32'd0, 0, rd);
    check_eq("rdata_lo", 64'(rd), 64'hCAFE_F00D);
    dmi(AData1, 2'd1, 32'd0, 0, rd);
    check_eq("rdata_hi", 64'(rd), 64'hDEAD_BEEF);

    // Write with autoincrement; completion without pending read keeps data
    dmi(ASbcs, 2'd2, 32'h0005_0000, 0, rd);
    dmi(AData0, 2'd2, 32'h1234_5678, 0, rd);
    master_complete(64'h1004, 64'h1111_2222_3333_4444);
    check_eq("autoinc_addr", sbaddress_o, 64'h1004);
    check_eq("data_kept", sbdata_o, 64'hDEAD_BEEF_1234_5678);

    // Busy error
    sbbusy_i = 1'b1;
    dmi(AAddr0, 2'd2, 32'h5555_5555, 0, rd);
    sbbusy_i = 1'b0;
    dmi(AData0, 2'd1, 32'd0, 0, rd);
    dmi(ASbcs, 2'd1, 32'd0, 0, rd);
    check_eq("busyerr_set", 64'(rd[22]), 64'd1);
    dmi(ASbcs, 2'd2, 32'h0045_0000, 0, rd);
    dmi(ASbcs, 2'd1, 32'd0, 0, rd);
    check_eq("busyerr_clr", 64'(rd[22]), 64'd0);

    // Master error, then W1C racing a new error strobe
    master_error(3'd3);
    dmi(ASbcs, 2'd1, 32'd0, 0, rd);
    check_eq("sberror_set", 64'(rd[14:12]), 64'd3);
    dmi(AAddr0, 2'd2, 32'h9999_0000, 0, rd);
    g_err_with_req = 1'b1; g_err_code = 3'd5;
    dmi(ASbcs, 2'd2, 32'h0005_7000, 0, rd);
    g_err_with_req = 1'b0;
    dmi(ASbcs, 2'd1, 32'd0, 5, rd);
    check_eq("sberror_race", 64'(rd[14:12]), 64'd3);
    dmi(ASbcs, 2'd2, 32'h0005_7000, 0, rd);
    dmi(ASbcs, 2'd1, 32'd0, 0, rd);
    check_eq("sberror_w1c", 64'(rd[14:12]), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        master_complete({$urandom, $urandom}, {$urandom, $urandom});
      end else if (r == 1) begin
        master_error(3'($urandom_range(0, 7)));
      end else begin
        sbbusy_i = ($urandom_range(0, 4) == 0);
        dmi(addrs[$urandom_range(0, 6)], 2'($urandom_range(0, 3)), $urandom, 0, rd);
        sbbusy_i = 1'b0;
      end
    end

    // dmactive drop during a pending response
    dmi(AAddr1, 2'd2, 32'hFFFF_0000, 0, rd);
    dmi(AData1, 2'd2, 32'h0000_FFFF, 0, rd);
    dmi_req_valid_i = 1'b1; dmi_req_addr_i = AAddr1; dmi_req_op_i = 2'd1;
    @(posedge clk_i); #1;
    dmi_req_valid_i = 1'b0;
    check_eq("pre_drop_valid", 64'(dmi_resp_valid_o), 64'd1);
    dmactive_i = 1'b0;
    @(posedge clk_i); #1;
    model_reset();
    check_eq("drop_valid", 64'(dmi_resp_valid_o), 64'd0);
    check_eq("drop_ready", 64'(dmi_req_ready_o), 64'd1);
    check_eq("drop_data", 64'(dmi_resp_data_o), 64'd0);
    check_no_pulse("drop");
    check_outputs("drop");
    dmactive_i = 1'b1;
    @(posedge clk_i); #1;
    dmi(ASbcs, 2'd1, 32'd0, 0, rd);
    check_eq("sbcs_after_drop", 64'(rd), 64'h2004_080F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
